// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, sizing defaults and owner type for the cache-fill arbiter
package mem_arbiter_pkg;
  localparam int DEF_MEM_LAT = 4;
  localparam int DEF_BURST_LEN = 8;
  localparam logic [2:0] ST_FLUSH = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/arb_count3.sv
// arb_count3: 3-bit up counter with enable, synchronous clear and count==7 terminal flag
module arb_count3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] cnt,
  output logic       tc
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 3'd1;
  assign tc = cnt == 3'd7;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I/D cache block fills and D write-through stores onto one pipelined memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_ack,
  output logic        i_busy,
  output logic        d_busy
);
  localparam int WORD_W = $clog2(BURST_LEN);
  logic [2:0] state, nxt;
  owner_e owner;
  logic [14-WORD_W:0] blk;
  logic [2:0] issue_cnt, rtn_cnt;
  logic issue_tc, rtn_tc, grant, in_fill, strobe, last, flush_done, own_d;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[WORD_W:0], d_miss_addr[WORD_W:0]};
  assign grant = state == ST_IDLE && !d_wr_req && (d_miss || i_miss);
  assign in_fill = state == ST_ISSUE || state == ST_DRAIN;
  assign strobe = in_fill && mem_data_valid;
  assign last = strobe && rtn_tc;
  assign own_d = owner == OWN_D;
  // The return counter doubles as the flush timer, so it is cleared when flush ends
  assign flush_done = state == ST_FLUSH && rtn_cnt == 3'(MEM_LAT - 1);
  arb_count3 u_issue (
    .clk(clk),
    .rst(rst),
    .en (state == ST_ISSUE),
    .clr(state != ST_ISSUE),
    .cnt(issue_cnt),
    .tc (issue_tc)
  );
  arb_count3 u_rtn (
    .clk(clk),
    .rst(rst),
    .en (state == ST_FLUSH || strobe),
    .clr(flush_done || state == ST_IDLE || state == ST_WRITE),
    .cnt(rtn_cnt),
    .tc (rtn_tc)
  );
  always_comb begin
    nxt = state;
    case (state)
      ST_FLUSH: nxt = flush_done ? ST_IDLE : ST_FLUSH;
      ST_IDLE:  nxt = d_wr_req ? ST_WRITE : (d_miss || i_miss) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: nxt = issue_tc ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: nxt = last ? ST_IDLE : ST_DRAIN;
      ST_WRITE: nxt = ST_IDLE;
      default:  nxt = ST_FLUSH;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_FLUSH;
      owner <= OWN_I;
      blk <= '0;
    end else begin
      state <= nxt;
      if (grant) begin
        owner <= d_miss ? OWN_D : OWN_I;
        blk <= d_miss ? d_miss_addr[15:WORD_W+1] : i_miss_addr[15:WORD_W+1];
      end
    end
  always_comb begin
    mem_enable = state == ST_ISSUE || state == ST_WRITE;
    mem_wr = state == ST_WRITE;
    mem_addr = state == ST_ISSUE ? {blk, issue_cnt[WORD_W-1:0], 1'b0} :
               state == ST_WRITE ? d_wr_addr : 16'h0;
    mem_data_in = state == ST_WRITE ? d_wr_data : 16'h0;
    d_wr_ack = state == ST_WRITE;
    fill_data = in_fill ? mem_data_out : 16'h0;
    fill_word = in_fill ? rtn_cnt : 3'd0;
    i_data_valid = strobe && !own_d;
    d_data_valid = strobe && own_d;
    i_fill_done = last && !own_d;
    d_fill_done = last && own_d;
    i_busy = in_fill && !own_d;
    d_busy = in_fill && own_d;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle-by-cycle checks of fill bursts, writes, priority and reset flush
module tb_mem_arbiter;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic rst;
  logic i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
  logic i_data_valid, d_data_valid, i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy;
  logic [2:0] fill_word;
  logic stray;
  logic pv [LAT];
  logic [15:0] pa [LAT];
  int n_checks = 0;
  int n_err = 0;
  logic [59:0] obs;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack),
    .i_busy(i_busy), .d_busy(d_busy)
  );
  assign obs = {mem_enable, mem_wr, mem_addr, mem_data_in, i_data_valid, d_data_valid, fill_word,
                fill_data, i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy};
  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction
  // r: cycles since the grant cycle of a burst (issue at 1..8, returns at 5..12)
  function automatic logic [59:0] burst_exp(input int r, input logic own_d, input logic [15:0] base);
    logic en, v, busy, done;
    logic [15:0] a, dat;
    logic [2:0] w;
    en = r >= 1 && r <= 8;
    v = r >= 5 && r <= 12;
    busy = r >= 1 && r <= 12;
    done = r == 12;
    a = en ? base + 16'(2 * (r - 1)) : 16'h0;
    w = v ? 3'(r - 5) : 3'd0;
    dat = v ? mdata(base + 16'(2 * (r - 5))) : 16'h0;
    return {en, 1'b0, a, 16'h0, v & !own_d, v & own_d, w, dat, done & !own_d, done & own_d,
            1'b0, busy & !own_d, busy & own_d};
  endfunction
  function automatic logic [59:0] write_exp(input logic [15:0] a, input logic [15:0] d);
    return {1'b1, 1'b1, a, d, 2'b00, 3'd0, 16'h0, 2'b00, 1'b1, 2'b00};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic cv;
    logic [15:0] ca;
    cv = mem_enable & ~mem_wr;
    ca = mem_addr;
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = cv;
    pa[0] = ca;
    mem_data_valid = pv[LAT-1] | stray;
    mem_data_out = pv[LAT-1] ? mdata(pa[LAT-1]) : 16'h0;
    #1;
  endtask
  initial begin
    rst = 1'b0;
    {i_miss, d_miss, d_wr_req} = '0;
    {i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data} = '0;
    mem_data_valid = 1'b0;
    mem_data_out = 16'h0;
    stray = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0;
    end
    #1;
    check("reset_async", 64'(obs), 64'h0);
    step();
    step();
    check("reset_stray", 64'(obs), 64'h0);
    rst = 1'b1;
    i_miss = 1'b1;
    i_miss_addr = 16'h1234;
    // flush occupies r=0..3, grant at r=4, so the burst is offset by 4
    for (int r = 0; r <= 17; r++) begin
      check($sformatf("ifill_r%0d", r), 64'(obs), 64'(burst_exp(r - 4, 1'b0, 16'h1230)));
      if (r == 3) stray = 1'b0;
      if (r == 16) begin
        i_miss = 1'b0;
        stray = 1'b1;
      end
      if (r == 17) stray = 1'b0;
      step();
    end
    d_miss = 1'b1;
    d_miss_addr = 16'h4000;
    i_miss = 1'b1;
    i_miss_addr = 16'h8000;
    for (int r = 0; r <= 26; r++) begin
      check($sformatf("prio_r%0d", r), 64'(obs),
            64'(r <= 12 ? burst_exp(r, 1'b1, 16'h4000) : burst_exp(r - 13, 1'b0, 16'h8000)));
      if (r == 12) d_miss = 1'b0;
      if (r == 25) i_miss = 1'b0;
      step();
    end
    d_miss = 1'b1;
    d_miss_addr = 16'h2000;
    for (int r = 0; r <= 15; r++) begin
      check($sformatf("wrwait_r%0d", r), 64'(obs),
            64'(r == 14 ? write_exp(16'h0ABC, 16'h5A5A) : burst_exp(r, 1'b1, 16'h2000)));
      if (r == 3) begin
        d_wr_req = 1'b1;
        d_wr_addr = 16'h0ABC;
        d_wr_data = 16'h5A5A;
      end
      if (r == 12) d_miss = 1'b0;
      if (r == 14) d_wr_req = 1'b0;
      step();
    end
    d_wr_req = 1'b1;
    d_wr_addr = 16'h1110;
    d_wr_data = 16'hBEEF;
    d_miss = 1'b1;
    d_miss_addr = 16'h3000;
    for (int r = 0; r <= 15; r++) begin
      check($sformatf("wrfirst_r%0d", r), 64'(obs),
            64'(r == 1 ? write_exp(16'h1110, 16'hBEEF) : burst_exp(r - 2, 1'b1, 16'h3000)));
      if (r == 1) d_wr_req = 1'b0;
      if (r == 14) d_miss = 1'b0;
      step();
    end
    i_miss = 1'b1;
    i_miss_addr = 16'h5670;
    // reset mid-burst at r=6; flush r=7..10, regrant at r=11
    for (int r = 0; r <= 24; r++) begin
      check($sformatf("rstmid_r%0d", r), 64'(obs),
            64'(r < 7 ? burst_exp(r, 1'b0, 16'h5670) : burst_exp(r - 11, 1'b0, 16'h5670)));
      if (r == 6) begin
        rst = 1'b0;
        #1;
        check("rstmid_abort", 64'(obs), 64'h0);
        stray = 1'b1;
      end
      if (r == 7) rst = 1'b1;
      if (r == 10) stray = 1'b0;
      if (r == 23) i_miss = 1'b0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
